// File: rtl/spi_pmodals_responder.sv
// SPI responder that stands in for the PmodALS light sensor (ADC081S021).
// Serves a programmable 8-bit sample framed by leading/trailing zeros,
// MSB first, to a master that samples MISO on SCK rising edges.
module spi_pmodals_responder #(
    parameter int FRAME_BITS  = 16,
    parameter int LEAD_ZEROS  = 4,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_100Mhz_pi,
    input  logic                 rst_pi,
    input  logic                 sck_pi,
    input  logic                 cs_pi,
    output logic                 miso_po,
    input  logic [DATA_BITS-1:0] sample_pi,
    input  logic                 sample_valid_pi,
    output logic [DATA_BITS-1:0] sample_latched_po,
    output logic                 busy_po,
    output logic                 frame_done_po,
    output logic                 abort_po,
    output logic [15:0]          frame_cnt_po
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, cs_s;
    logic [SYNC_STAGES:0]   settle_sr;
    logic                   settled;
    logic                   cs_armed;

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic start_frame, end_frame, do_rise, do_fall;

    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] frame_word;
    logic [CW-1:0]         rise_cnt, fall_cnt;
    logic [DATA_BITS-1:0]  sample_q;
    logic                  miso_q, busy_q, frame_done_q, abort_q;
    logic [15:0]           frame_cnt_q;

    // Place the sample after the leading zeros; remaining bits stay zero.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] s);
        logic [FRAME_BITS-1:0] w;
        w = '0;
        w[FRAME_BITS-1-LEAD_ZEROS -: DATA_BITS] = s;
        return w;
    endfunction

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign cs_s  = cs_sync[SYNC_STAGES-1];
    assign settled = settle_sr[SYNC_STAGES];

    // Synchronize the asynchronous SPI pins and keep one extra flop for edge detect.
    always_ff @(posedge clk_100Mhz_pi) begin
        if (rst_pi) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_pi};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_pi};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
        end
    end

    // The cs chain resets high, so a low pin right after reset would look like a
    // falling edge; only arm frame starts once real pin data has reached the
    // synchronizer output and shown cs high.
    always_ff @(posedge clk_100Mhz_pi) begin
        if (rst_pi) begin
            settle_sr <= '0;
            cs_armed  <= 1'b0;
        end else begin
            settle_sr <= {settle_sr[SYNC_STAGES-1:0], 1'b1};
            if (settled && cs_s)
                cs_armed <= 1'b1;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = cs_armed & cs_d & ~cs_s;

    // State register.
    always_ff @(posedge clk_100Mhz_pi) begin
        if (rst_pi)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state and per-cycle actions; a cs rise masks any sck edge in the same cycle.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        do_rise     = 1'b0;
        do_fall     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    start_frame = 1'b1;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    end_frame = 1'b1;
                    state_d   = IDLE;
                end else begin
                    do_rise = sck_rise;
                    do_fall = sck_fall;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame word: a strobe in the start cycle bypasses the holding register.
    always_comb begin
        frame_word = build_frame(sample_valid_pi ? sample_pi : sample_q);
    end

    // Holding register, shift register, bit counters and status outputs.
    always_ff @(posedge clk_100Mhz_pi) begin
        if (rst_pi) begin
            sample_q     <= '0;
            shift_q      <= '0;
            rise_cnt     <= '0;
            fall_cnt     <= '0;
            miso_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            if (sample_valid_pi)
                sample_q <= sample_pi;
            if (start_frame) begin
                shift_q  <= frame_word;
                miso_q   <= frame_word[FRAME_BITS-1];
                rise_cnt <= '0;
                fall_cnt <= '0;
                busy_q   <= 1'b1;
            end else if (end_frame) begin
                miso_q <= 1'b0;
                busy_q <= 1'b0;
                if (rise_cnt >= CW'(FRAME_BITS)) begin
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                end else begin
                    abort_q <= 1'b1;
                end
            end else begin
                if (do_rise && (rise_cnt != '1))
                    rise_cnt <= rise_cnt + 1'b1;
                if (do_fall) begin
                    if (fall_cnt < CW'(FRAME_BITS - 1)) begin
                        shift_q  <= shift_q << 1;
                        miso_q   <= shift_q[FRAME_BITS-2];
                        fall_cnt <= fall_cnt + 1'b1;
                    end else begin
                        miso_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign miso_po           = miso_q;
    assign busy_po           = busy_q;
    assign frame_done_po     = frame_done_q;
    assign abort_po          = abort_q;
    assign frame_cnt_po      = frame_cnt_q;
    assign sample_latched_po = sample_q;

endmodule

// File: tb/tb_spi_pmodals_responder.sv
// Directed bench for spi_pmodals_responder: a behavioural SPI master runs
// frames at 1 MHz sck and compares against a queue of expected frames.
module tb_spi_pmodals_responder;

    localparam int HALF = 50;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_pi, sck_pi, cs_pi, sample_valid_pi;
    logic [7:0] sample_pi;
    logic       miso_po, busy_po, frame_done_po, abort_po;
    logic [7:0] sample_latched_po;
    logic [15:0] frame_cnt_po;

    typedef struct {
        logic [15:0] word;
        int          kind;   // 0 full frame, 1 abort, 2 reset mid-frame
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_cnt;
    logic [7:0]  exp_latched;
    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    int          abort_seen = 0;

    always #5 clk = ~clk;

    spi_pmodals_responder dut (
        .clk_100Mhz_pi     (clk),
        .rst_pi            (rst_pi),
        .sck_pi            (sck_pi),
        .cs_pi             (cs_pi),
        .miso_po           (miso_po),
        .sample_pi         (sample_pi),
        .sample_valid_pi   (sample_valid_pi),
        .sample_latched_po (sample_latched_po),
        .busy_po           (busy_po),
        .frame_done_po     (frame_done_po),
        .abort_po          (abort_po),
        .frame_cnt_po      (frame_cnt_po)
    );

    always @(negedge clk) begin
        if (frame_done_po) done_seen++;
        if (abort_po) abort_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic latch(input logic [7:0] v);
        sample_pi = v;
        sample_valid_pi = 1'b1;
        @(negedge clk);
        sample_valid_pi = 1'b0;
        exp_latched = v;
        check("latched", {24'b0, sample_latched_po}, {24'b0, exp_latched});
    endtask

    task automatic run_frame(input string tag, input int n_sck, input int strobe_at,
                             input logic [7:0] strobe_val, input int rst_at,
                             input bit bypass, input logic [7:0] byp_val);
        logic [31:0] cap;
        logic [31:0] want;
        exp_t        e;
        int          d0, a0;
        d0  = done_seen;
        a0  = abort_seen;
        cap = '0;
        cs_pi = 1'b0;
        if (bypass) begin
            repeat (2) @(negedge clk);
            sample_pi = byp_val;
            sample_valid_pi = 1'b1;
            @(negedge clk);
            sample_valid_pi = 1'b0;
            repeat (HALF - 3) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        for (int i = 0; i < n_sck; i++) begin
            if (i == strobe_at) begin
                sample_pi = strobe_val;
                sample_valid_pi = 1'b1;
                @(negedge clk);
                sample_valid_pi = 1'b0;
            end
            if (i == rst_at) begin
                rst_pi = 1'b1;
                @(negedge clk);
                rst_pi = 1'b0;
            end
            sck_pi = 1'b1;
            cap = {cap[30:0], miso_po};
            if (i == 2 && rst_at < 0)
                check({tag, "_busy_mid"}, {31'b0, busy_po}, 32'd1);
            repeat (HALF) @(negedge clk);
            sck_pi = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        if (rst_at >= 0)
            check({tag, "_idle_after_rst"}, {31'b0, busy_po}, 32'd0);
        cs_pi = 1'b1;
        repeat (SYNC + 5) @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != 2) begin
                want = (n_sck <= 16) ? ({16'b0, e.word} >> (16 - n_sck))
                                     : ({16'b0, e.word} << (n_sck - 16));
                check({tag, "_word"}, cap, want);
            end
            check({tag, "_done"}, done_seen - d0, (e.kind == 0) ? 32'd1 : 32'd0);
            check({tag, "_abort"}, abort_seen - a0, (e.kind == 1) ? 32'd1 : 32'd0);
        end
        check({tag, "_cnt"}, {16'b0, frame_cnt_po}, {16'b0, exp_cnt});
        check({tag, "_busy"}, {31'b0, busy_po}, 32'd0);
        check({tag, "_miso"}, {31'b0, miso_po}, 32'd0);
        check({tag, "_latched"}, {24'b0, sample_latched_po}, {24'b0, exp_latched});
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst_pi = 1'b1;
        sck_pi = 1'b0;
        cs_pi = 1'b1;
        sample_valid_pi = 1'b0;
        sample_pi = 8'h00;
        exp_cnt = 16'd0;
        exp_latched = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_miso", {31'b0, miso_po}, 32'd0);
        check("rst_busy", {31'b0, busy_po}, 32'd0);
        check("rst_done", {31'b0, frame_done_po}, 32'd0);
        check("rst_abort", {31'b0, abort_po}, 32'd0);
        check("rst_cnt", {16'b0, frame_cnt_po}, 32'd0);
        check("rst_latched", {24'b0, sample_latched_po}, 32'd0);
        rst_pi = 1'b0;
        repeat (10) @(negedge clk);

        // Full-scale sample.
        latch(8'hFF);
        exp_q.push_back('{16'h0FF0, 0}); exp_cnt = 16'd1;
        run_frame("ff", 16, -1, 8'h00, -1, 1'b0, 8'h00);

        // Alternating pattern.
        latch(8'hA5);
        exp_q.push_back('{16'h0A50, 0}); exp_cnt = 16'd2;
        run_frame("a5", 16, -1, 8'h00, -1, 1'b0, 8'h00);

        // Mid-frame strobe only affects the next frame.
        latch(8'h81);
        exp_q.push_back('{16'h0810, 0}); exp_cnt = 16'd3; exp_latched = 8'h3C;
        run_frame("mid_strobe", 16, 5, 8'h3C, -1, 1'b0, 8'h00);
        exp_q.push_back('{16'h03C0, 0}); exp_cnt = 16'd4;
        run_frame("after_strobe", 16, -1, 8'h00, -1, 1'b0, 8'h00);

        // Short frame aborts, then a full frame recovers.
        exp_q.push_back('{16'h03C0, 1});
        run_frame("abort7", 7, -1, 8'h00, -1, 1'b0, 8'h00);
        exp_q.push_back('{16'h03C0, 0}); exp_cnt = 16'd5;
        run_frame("post_abort", 16, -1, 8'h00, -1, 1'b0, 8'h00);

        // Strobe in the cs-fall detection cycle is served directly.
        exp_q.push_back('{16'h05A0, 0}); exp_cnt = 16'd6; exp_latched = 8'h5A;
        run_frame("bypass", 16, -1, 8'h00, -1, 1'b1, 8'h5A);

        // Extra sck edges still count as a complete frame; tail bits are zero.
        exp_q.push_back('{16'h05A0, 0}); exp_cnt = 16'd7;
        run_frame("extra_sck", 18, -1, 8'h00, -1, 1'b0, 8'h00);

        // Reset at bit 9 with cs held low: no pulse, block waits for a fresh cs fall.
        latch(8'h77);
        exp_q.push_back('{16'h0000, 2}); exp_cnt = 16'd0; exp_latched = 8'h00;
        run_frame("rst_mid", 16, -1, 8'h00, 9, 1'b0, 8'h00);
        latch(8'h66);
        exp_q.push_back('{16'h0660, 0}); exp_cnt = 16'd1;
        run_frame("post_rst", 16, -1, 8'h00, -1, 1'b0, 8'h00);

        // Frame counter wraps from 16'hFFFF to 0.
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        exp_q.push_back('{16'h0660, 0}); exp_cnt = 16'hFFFF + 16'd1;
        run_frame("wrap", 16, -1, 8'h00, -1, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_pmodals_responder.md
Name: spi_pmodals_responder

Overview:
- Synthesizable SPI peripheral that emulates the PmodALS light sensor, the ADC081S021 SPI ADC.
- Answers our SPI master's read frames with a programmable 8-bit sample, so the master/display chain can be self-checked on board and in simulation without the physical Pmod.
- Sits beside the master in the top level: master cs_ctrl/sck drive this block, its miso returns to the master.
- Runs on the system clock and oversamples the SPI pins.

Parameters:
- FRAME_BITS, 16, SCK cycles per frame.
- LEAD_ZEROS, 4, zero bits sent before the data MSB.
- DATA_BITS, 8, sample width. Constraint: LEAD_ZEROS+DATA_BITS <= FRAME_BITS. Trailing zeros = FRAME_BITS-LEAD_ZEROS-DATA_BITS.
- SYNC_STAGES, 2, flip-flop stages on the sck_pi and cs_pi synchronizers (>=2).

Ports:
- clk_100Mhz_pi  in  1  system clock.
- rst_pi  in  1  synchronous, active-high reset.
- sck_pi  in  1  SPI clock from the master, asynchronous.
- cs_pi  in  1  chip select, active low, asynchronous.
- miso_po  out  1  serial data to the master.
- sample_pi  in  DATA_BITS  value to serve.
- sample_valid_pi  in  1  one-cycle strobe; latches sample_pi into the holding register.
- sample_latched_po  out  DATA_BITS  current holding register.
- busy_po  out  1  high while a frame is active.
- frame_done_po  out  1  one-cycle pulse when a complete frame ends.
- abort_po  out  1  one-cycle pulse when cs rises before FRAME_BITS sck rising edges.
- frame_cnt_po  out  16  count of completed frames, wraps at 16'hFFFF.

Behaviour:
- Reset: miso_po=0, busy_po=0, frame_done_po=0, abort_po=0, frame_cnt_po=0, sample_latched_po=0. Shift register and bit counters cleared. FSM goes to IDLE. Synchronizer flops reset to sck=0, cs=1.
- Sync and edge detect: sck and cs each pass through SYNC_STAGES flops plus one edge-detect flop. All pin-to-response latency is SYNC_STAGES+1 clk cycles (3 with defaults). The master must keep each sck half-period >= SYNC_STAGES+2 clk cycles (>=4 at defaults).
- Holding register: loads sample_pi on sample_valid_pi, in any state.
- FSM IDLE:
  - miso_po=0.
  - On the detected cs falling edge: load the shift register with {LEAD_ZEROS zeros, frame sample, trailing zeros}, MSB first. Drive the frame MSB on miso_po. Clear rise_cnt and fall_cnt, set busy_po=1, go to SHIFT.
  - Frame sample = sample_pi if sample_valid_pi is high in that same cycle (bypass), else the holding register.
- FSM SHIFT:
  - Each detected sck rising edge increments rise_cnt; this is the master sampling point.
  - Each detected sck falling edge shifts left by one and drives the next bit on miso_po, then increments fall_cnt.
  - After fall_cnt reaches FRAME_BITS-1, later falling edges drive 0.
  - sample_valid_pi during SHIFT updates only the holding register; the change takes effect on the next frame.
  - On the detected cs rising edge: miso_po=0, busy_po=0, go to IDLE.
    - If rise_cnt>=FRAME_BITS: pulse frame_done_po and increment frame_cnt_po (16'hFFFF wraps to 0).
    - Otherwise: pulse abort_po and leave frame_cnt_po unchanged.
- sck edges while cs is high are ignored.
- Simultaneous cs rise and sck edge in the same cycle: cs rise wins and the sck edge is discarded.
- Reset mid-frame: everything returns to reset values next cycle and no pulse is generated.
  - If cs is low when reset deasserts, the block stays IDLE until cs goes high then low; the reset value of the cs sync flops makes a low cs look like a falling edge, so edge detect must be qualified with the cs-high history after reset.
- Extra sck rising edges beyond FRAME_BITS are counted (saturating) and still produce frame_done, not abort.

Test Plan:
- Latch 8'hFF, run one 16-bit master frame (sck 1 MHz) -> master samples 16'b0000_1111_1111_0000; dato/display shows 8'hFF; frame_done_po pulses once; frame_cnt_po=1.
- Latch 8'hA5, frame -> miso bit sequence 0000_1010_0101_0000; sample_latched_po=8'hA5; the master's decoded byte equals 8'hA5.
- Strobe sample_valid_pi=8'h3C mid-frame while serving 8'h81 -> current frame returns 8'h81, next frame returns 8'h3C.
- Raise cs after 7 sck cycles -> abort_po pulses, frame_cnt_po unchanged, miso_po=0, busy_po=0; the following full frame is correct.
- Assert rst_pi for 1 cycle at bit 9 with cs held low -> no frame_done; no frame starts until cs goes high then low; the next frame is correct.
- Preload frame_cnt_po to 16'hFFFF via 65535 fast frames (or force), one more frame -> frame_cnt_po=0.
